// File: rtl/alu_pkg.sv
// Shared types and defaults for the round-robin ALU scheduler.
package alu_pkg;
  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 2;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW-1:0] j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = PW'((int'(ptr) + i) % NREQ);
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler time-sharing one registered ALU among NREQ requesters.
// Handshake: a requester holds req until it sees its done pulse and drops it by the
// following cycle; req is only sampled in IDLE, and gnt stays high for the whole transaction.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      result,
  output logic                   busy,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_y,
  output state_t                 dbg_state
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;

  logic [NREQ-1:0]   pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    busy_d   = busy_q;
    result_d = result_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = EXEC;
          gnt_d    = pick_onehot;
          win_d    = pick_idx;
          busy_d   = 1'b1;
          cnt_d    = CNT_W'(ALU_LAT);
          alu_a_d  = req_a[int'(pick_idx)*DATA_W +: DATA_W];
          alu_b_d  = req_b[int'(pick_idx)*DATA_W +: DATA_W];
          alu_op_d = req_op[int'(pick_idx)*OP_W +: OP_W];
        end
      end
      EXEC: begin
        // Counting down to zero gives y one full cycle past its ALU register edge.
        if (cnt_q == '0) begin
          state_d  = CAPT;
          result_d = alu_y;
          done_d   = gnt_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPT: begin
        state_d = IDLE;
        done_d  = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a one-cycle registered ALU model alongside.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 16;
  localparam int OP_W    = 2;
  localparam int ALU_LAT = 1;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      result;
  logic                   busy;
  logic [DATA_W-1:0]      alu_a;
  logic [DATA_W-1:0]      alu_b;
  logic [OP_W-1:0]        alu_op;
  logic [DATA_W-1:0]      alu_y = '0;
  state_t                 dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    int               idx;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] y;
  } vec_t;
  vec_t vecs[5];

  alu_rr_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(ALU_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ALU model: 00 add, 01 sub, 10 and, 11 or
  function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [OP_W-1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  always_ff @(posedge clk) alu_y <= alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_slot(input int i, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
    req_op[i*OP_W +: OP_W]    = op;
  endtask

  // Waits for requester w's grant, follows it to done, then drops req[w] in the idle cycle.
  task automatic serve(input int w, input logic [DATA_W-1:0] exp_y);
    int t;
    int lat;
    logic got;
    logic [NREQ-1:0] oh;
    oh = 4'b0001 << w;
    exp_q.push_back(exp_y);
    got = 1'b0;
    for (t = 0; t < 16; t++) begin
      @(negedge clk);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    check("gnt_seen", 32'(got), 32'd1);
    check("gnt_lat", t, 0);
    check("gnt_onehot", 32'(gnt), 32'(oh));
    check("busy_in_txn", 32'(busy), 32'd1);
    got = 1'b0;
    for (lat = 1; lat <= 16; lat++) begin
      @(negedge clk);
      if (done != '0) begin got = 1'b1; break; end
    end
    check("done_seen", 32'(got), 32'd1);
    check("done_lat", lat, ALU_LAT + 1);
    check("done_onehot", 32'(done), 32'(oh));
    check("gnt_held", 32'(gnt), 32'(oh));
    if (exp_q.size() > 0) check("result", 32'(result), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("busy_gap", 32'(busy), 32'd0);
    check("gnt_clear", 32'(gnt), 32'd0);
    req[w] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vecs[0] = '{idx: 2, a: 16'h0003, b: 16'h0005, op: 2'b00, y: 16'h0008};
    vecs[1] = '{idx: 1, a: 16'hFFFF, b: 16'h0001, op: 2'b00, y: 16'h0000};
    vecs[2] = '{idx: 0, a: 16'h0005, b: 16'h0007, op: 2'b01, y: 16'hFFFE};
    vecs[3] = '{idx: 3, a: 16'hABCD, b: 16'h0FF0, op: 2'b10, y: 16'h0BC0};
    vecs[4] = '{idx: 2, a: 16'h1200, b: 16'h0034, op: 2'b11, y: 16'h1234};

    // reset with all requests pending
    reset = 1'b0;
    req   = 4'b1111;
    set_slot(0, 16'h0001, 16'h0002, 2'b00);
    set_slot(1, 16'h0009, 16'h0004, 2'b01);
    set_slot(2, 16'h00F0, 16'h0FF0, 2'b10);
    set_slot(3, 16'h0F00, 16'h00F0, 2'b11);
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;

    // contention: order 0,1,2,3
    serve(0, 16'h0003);
    serve(1, 16'h0005);
    serve(2, 16'h00F0);
    serve(3, 16'h0FF0);

    // wrap and fairness
    set_slot(0, 16'h0010, 16'h0020, 2'b00);
    set_slot(3, 16'h0100, 16'h0001, 2'b01);
    req = 4'b1001;
    serve(0, 16'h0030);
    req[0] = 1'b1;
    serve(3, 16'h00FF);
    serve(0, 16'h0030);

    // single requests from the table
    foreach (vecs[k]) begin
      set_slot(vecs[k].idx, vecs[k].a, vecs[k].b, vecs[k].op);
      req = 4'b0001 << vecs[k].idx;
      serve(vecs[k].idx, vecs[k].y);
    end

    // operand stability
    set_slot(1, 16'h00FF, 16'h0001, 2'b00);
    req = 4'b0010;
    @(negedge clk);
    check("stab_gnt", 32'(gnt), 32'h2);
    set_slot(1, 16'h1234, 16'h0001, 2'b00);
    @(negedge clk);
    check("stab_alu_a_exec", 32'(alu_a), 32'h00FF);
    check("stab_state", 32'(dbg_state), 32'(EXEC));
    @(negedge clk);
    check("stab_done", 32'(done), 32'h2);
    check("stab_alu_a_capt", 32'(alu_a), 32'h00FF);
    check("stab_result", 32'(result), 32'h0100);
    @(negedge clk);
    check("stab_busy", 32'(busy), 32'd0);
    req = 4'b0000;

    // request withdrawn mid-EXEC still completes
    set_slot(2, 16'h0007, 16'h0002, 2'b01);
    req = 4'b0100;
    @(negedge clk);
    check("drop_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("drop_done", 32'(done), 32'h4);
    check("drop_result", 32'(result), 32'h0005);
    @(negedge clk);
    check("drop_busy", 32'(busy), 32'd0);

    // reset during EXEC discards the transaction and clears ptr
    set_slot(3, 16'h0001, 16'h0001, 2'b00);
    req = 4'b1000;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'h8);
    check("abort_state", 32'(dbg_state), 32'(EXEC));
    reset = 1'b0;
    #1;
    check("abort_gnt_clr", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_idle", 32'(dbg_state), 32'(IDLE));
    req  = 4'b0000;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    reset = 1'b1;
    set_slot(1, 16'h0002, 16'h0003, 2'b00);
    set_slot(3, 16'h8000, 16'h8001, 2'b10);
    req = 4'b1010;
    serve(1, 16'h0005);
    serve(3, 16'h8000);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
